// File: rtl/stream_mux_rr.sv
// ---------------------------------------------------------------------------
// stream_mux_rr
//
// N-channel valid/ready stream multiplexer with one output register stage.
// Each cycle one channel is granted, either by a fixed index or by round-robin.
// The granted word and its channel index are captured in the output register.
// The register refills in the same cycle that it drains, so a continuous
// stream runs at one word per clock.
//
// Parameters
//   N_CH   number of input channels (>= 1)
//   WIDTH  data width per channel
//   CH_W   channel index width (derived, do not override)
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   mode       0 = fixed select via sel, 1 = round-robin
//   sel        channel index used when mode = 0
//   in_valid   per-channel valid, bit i = channel i
//   in_data    channel i data at bits [i*WIDTH +: WIDTH]
//   in_ready   per-channel ready (combinational, at most one bit set)
//   out_valid  output register holds a word
//   out_data   registered data
//   out_ch     index of the channel that supplied out_data
//   out_ready  consumer accepts out_data this cycle
// ---------------------------------------------------------------------------
module stream_mux_rr #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [CH_W-1:0]       sel,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [CH_W-1:0]       out_ch,
  input  logic                  out_ready
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [CH_W-1:0]  out_ch_reg;
  logic [CH_W-1:0]  last_ch_reg;   // channel of the most recent mode-1 grant

  // -------------------------------------------------------------------------
  // Grant signals
  // -------------------------------------------------------------------------
  logic             load;          // output register can take a word this cycle
  logic [CH_W-1:0]  gnt;
  logic             gnt_valid;
  logic             xfer;          // an input transfer happens this cycle

  // Per-channel data split out of the flat input bus.
  logic [WIDTH-1:0] ch_data [N_CH];

  genvar gi;

  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_split
      assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign load = !out_valid_reg || out_ready;

  generate
    if (N_CH == 1) begin : g_single
      // With a single channel there is nothing to arbitrate. mode and sel
      // do not matter, and the design is a plain pipeline register.
      assign gnt       = '0;
      assign gnt_valid = in_valid[0];
    end else begin : g_multi
      // ---------------------------------------------------------------------
      // Fixed select. The valid vector is zero-padded to the full index range,
      // so sel values past the last channel find valid = 0 and grant nothing.
      // ---------------------------------------------------------------------
      localparam int N_PAD = 2 ** CH_W;
      logic [N_PAD-1:0] valid_pad;
      logic             fx_valid;

      if (N_PAD > N_CH) begin : g_pad
        assign valid_pad = {{(N_PAD - N_CH){1'b0}}, in_valid};
      end else begin : g_nopad
        assign valid_pad = in_valid;
      end

      assign fx_valid = valid_pad[sel];

      // ---------------------------------------------------------------------
      // Round-robin. cand[k] is the channel that is k+1 places after
      // last_ch_reg, wrapped modulo N_CH and not modulo 2**CH_W. The sum is
      // one bit wider than CH_W, so (N_CH-1) + N_CH cannot overflow.
      // ---------------------------------------------------------------------
      logic [CH_W-1:0] cand       [N_CH];
      logic [N_CH-1:0] cand_valid;
      logic [CH_W-1:0] rr_gnt;
      logic            rr_hit;

      for (gi = 0; gi < N_CH; gi++) begin : g_cand
        logic [CH_W:0] sum;
        logic [CH_W:0] wrapped;
        assign sum     = {1'b0, last_ch_reg} + (CH_W+1)'(gi + 1);
        assign wrapped = (sum >= (CH_W+1)'(N_CH)) ? (sum - (CH_W+1)'(N_CH)) : sum;
        assign cand[gi]       = wrapped[CH_W-1:0];
        assign cand_valid[gi] = in_valid[cand[gi]];
      end

      // The loop runs from the highest candidate down to the lowest, so the
      // nearest valid channel after the pointer is the one left in rr_gnt.
      always_comb begin
        rr_gnt = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
          if (cand_valid[k]) begin
            rr_gnt = cand[k];
          end
        end
      end

      // Every channel appears once in the candidate list. So a hit occurs
      // exactly when any channel is valid.
      assign rr_hit = |in_valid;

      assign gnt       = mode ? rr_gnt : sel;
      assign gnt_valid = mode ? rr_hit : fx_valid;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Ready. It depends only on control inputs and state, never on in_data.
  // It is forced low while reset is asserted.
  // -------------------------------------------------------------------------
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ready
      assign in_ready[gi] = rst_n && load && gnt_valid && (gnt == CH_W'(gi));
    end
  endgenerate

  // gnt_valid means the granted channel's in_valid is set. So a granted,
  // loadable cycle is always an input transfer.
  assign xfer = load && gnt_valid;

  // -------------------------------------------------------------------------
  // Output register and round-robin pointer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      // Point at the last channel, so channel 0 is scanned first.
      last_ch_reg   <= CH_W'(N_CH - 1);
    end else begin
      if (xfer) begin
        // A simultaneous drain and refill replaces the word in place.
        out_valid_reg <= 1'b1;
        out_data_reg  <= ch_data[gnt];
        out_ch_reg    <= gnt;
        // Only round-robin grants move the pointer. Fixed-select traffic
        // leaves it alone, so returning to mode 1 resumes where it stopped.
        if (mode) begin
          last_ch_reg <= gnt;
        end
      end else if (out_ready) begin
        // Drain with no refill. Data and channel keep their last values.
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;

endmodule
